// File: rtl/bcd_to_binary.sv
// bcd_to_binary: multi-cycle packed-BCD to binary converter (reverse double-dabble).
//
// Parameters
//   DIGITS : number of packed BCD digits on bcd (MS digit in the top nibble)
//   BIN_W  : binary result width; the instantiator must ensure 2**BIN_W > 10**DIGITS - 1
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   start  : conversion request, accepted only when busy is low (IDLE or DONE)
//   bcd    : packed BCD input, captured when start is accepted
//   bin    : registered binary result, held until the next accepted start
//   busy   : high while a conversion is in progress (CHECK and SHIFT)
//   done   : one-cycle pulse marking bin/error valid
//   error  : captured input held a digit > 9; held until the next accepted start
//
// Sequence: accept -> CHECK (1 cycle) -> SHIFT (BIN_W cycles) -> DONE (1 cycle) -> IDLE.
// An invalid digit short-cuts CHECK straight to DONE with bin = 0 and error = 1.
module bcd_to_binary #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(BIN_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StShift,
    StDone
  } state_e;

  state_e            state_q;
  logic [BcdW-1:0]   bcd_q;
  logic [BIN_W-1:0]  bin_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              bad_digit;
  logic [BcdW-1:0]   sh_bcd;
  logic [BIN_W-1:0]  sh_bin;
  logic [BcdW-1:0]   adj_bcd;
  logic              accept;

  // Any captured nibble above 9 makes the input invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_q[4*d +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // One reverse double-dabble iteration: shift {bcd, bin} right, then pull every
  // digit that is >= 8 back by 3 so the next halving stays a valid BCD digit.
  always_comb begin
    {sh_bcd, sh_bin} = {bcd_q, bin_q} >> 1;
    adj_bcd          = sh_bcd;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (sh_bcd[4*d +: 4] >= 4'd8) begin
        adj_bcd[4*d +: 4] = sh_bcd[4*d +: 4] - 4'd3;
      end
    end
  end

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (accept) begin
      state_q <= StCheck;
      bcd_q   <= bcd;
      bin_q   <= '0;
      error_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        StCheck: begin
          if (bad_digit) begin
            error_q <= 1'b1;
            bin_q   <= '0;
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          bcd_q <= adj_bcd;
          bin_q <= sh_bin;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bin   = bin_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed self-checking bench for bcd_to_binary (DIGITS=3, BIN_W=10).
// Inputs are driven and outputs sampled on the falling edge; cycle 1 is the cycle right
// after the rising edge that accepts start.
module tb_bcd_to_binary;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_to_binary #(
    .DIGITS(3),
    .BIN_W (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bcd  (bcd),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done starting at cycle cyc0 and check latency, busy profile and result.
  task automatic wait_done(input string tag, input int cyc0, input int exp_bin,
                           input int exp_err, input int exp_lat, input bit tail);
    int cyc     = cyc0;
    int busy_n  = 0;
    while (!done && cyc < 50) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_lat - cyc0);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    check({tag, "_bin"}, {22'd0, bin}, exp_bin);
    check({tag, "_error"}, {31'd0, error}, exp_err);
    if (tail) begin
      @(negedge clk);
      check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
      check({tag, "_bin_held"}, {22'd0, bin}, exp_bin);
    end
  endtask

  task automatic run_conv(input string tag, input logic [11:0] v, input int exp_bin,
                          input int exp_err, input int exp_lat);
    bcd   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag, 1, exp_bin, exp_err, exp_lat, 1'b1);
  endtask

  typedef struct {
    logic [11:0] v;
    int          b;
    int          e;
    int          lat;
  } vec_t;

  vec_t vecs[7] = '{
    '{12'h999, 999, 0, 12},
    '{12'h000,   0, 0, 12},
    '{12'h512, 512, 0, 12},
    '{12'h4A7,   0, 1,  2},
    '{12'h047,  47, 0, 12},
    '{12'h900, 900, 0, 12},
    '{12'h00F,   0, 1,  2}
  };

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = '0;
    #3;
    check("reset_bin", {22'd0, bin}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_error", {31'd0, error}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_conv($sformatf("vec%0d_%03h", i, vecs[i].v), vecs[i].v, vecs[i].b, vecs[i].e,
               vecs[i].lat);
    end

    // Start re-pulsed mid-conversion, and bcd changed afterwards: both must be ignored.
    bcd   = 12'h250;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bcd   = 12'h123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd   = 12'h777;
    wait_done("ignore_start", 4, 250, 0, 12, 1'b1);

    // Start held high: a new acceptance in the DONE cycle gives back-to-back conversions.
    bcd   = 12'h001;
    start = 1'b1;
    @(negedge clk);
    wait_done("b2b_first", 1, 1, 0, 12, 1'b0);
    bcd = 12'h002;
    @(negedge clk);
    check("b2b_no_idle_busy", {31'd0, busy}, 1);
    check("b2b_no_idle_done", {31'd0, done}, 0);
    start = 1'b0;
    wait_done("b2b_second", 1, 2, 0, 12, 1'b1);

    // Reset during the 5th SHIFT cycle (cycle 6) aborts with no done pulse.
    bcd   = 12'h999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("abort_bin", {22'd0, bin}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_error", {31'd0, error}, 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("abort_no_done", seen, 0);
    run_conv("after_reset_321", 12'h321, 321, 0, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 Parameter DIGITS, default 3, sets the number of packed BCD input digits.
REQ-002 Parameter BIN_W, default 10, sets the binary result width; the instantiator SHALL guarantee 2^BIN_W > 10^DIGITS - 1.
REQ-003 Clock  input  1  single clock; all state changes on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request pulse; it is sampled on the rising edge of Clock.
REQ-006 BCD  input  4*DIGITS  packed BCD value, MS digit in the top nibble, captured when Start is accepted.
REQ-007 Bin  output  BIN_W  binary result, registered, held until the next accepted Start.
REQ-008 Busy  output  1  high while a conversion is in progress.
REQ-009 Done  output  1  one-cycle pulse marking Bin/Error valid.
REQ-010 Error  output  1  high when the captured input held a digit >9; held until the next accepted Start.

Function
REQ-011 The block SHALL implement FSM states IDLE, CHECK, SHIFT and DONE.
REQ-012 Start SHALL be accepted only when Busy=0, i.e. in IDLE or DONE.
- On acceptance: BCD is captured, Bin is cleared, Error is cleared, and the next state is CHECK.
- Start while Busy=1 SHALL be ignored, with no effect on state or captured data.
REQ-013 CHECK, one cycle:
- If any captured digit >9: Error=1, Bin=0, go to DONE.
- Otherwise: clear the shift counter and go to SHIFT.
REQ-014 SHIFT SHALL perform reverse double-dabble for exactly BIN_W cycles, one iteration per cycle.
- Shift the {BCD, Bin} register right by one.
- Then subtract 3 from every BCD digit that is >=8.
REQ-015 After the BIN_W-th iteration, the FSM SHALL go to DONE.
REQ-016 DONE SHALL last one cycle with Done=1 and then go to IDLE, unless Start is accepted in that cycle, in which case it goes to CHECK.
REQ-017 Valid-input latency: Done SHALL be high in the cycle following the (BIN_W+2)-th rising edge after the edge that sampled Start.
REQ-018 Invalid-input latency: Done SHALL be high in the cycle following the 2nd rising edge after the edge that sampled Start.
REQ-019 Busy SHALL be 1 in CHECK and SHIFT, and 0 in IDLE and DONE.
REQ-020 Done and Busy SHALL never be high in the same cycle.
REQ-021 Bin SHALL equal the decimal value of the captured BCD exactly; no saturation or truncation is permitted within the REQ-002 range.
REQ-022 Bin and Error SHALL not change outside acceptance, CHECK and SHIFT.
- Bin is only partial while Busy=1.
- Bin is stable from Done until the next acceptance.
REQ-023 BCD changing after acceptance SHALL not affect the result.

Reset
REQ-024 Reset=0 SHALL immediately, without waiting for a clock, force the following:
- state to IDLE
- Bin=0, Busy=0, Done=0, Error=0
- capture and shift registers to 0
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no Done pulse.
REQ-026 After Reset is released, the first Start SHALL convert normally.

Verification
REQ-027 BCD=0x999, Start pulse -> Busy for 11 cycles, Done pulse on the 12th cycle, Bin=999, Error=0.
REQ-028 BCD=0x000 -> Bin=0, Error=0, Done after 12 edges; BCD=0x512 -> Bin=512.
REQ-029 BCD=0x4A7 -> Done after 2 edges, Error=1, Bin=0; a following BCD=0x047 -> Error=0, Bin=47.
REQ-030 Start re-pulsed with BCD=0x123 while converting 0x250 -> ignored; result Bin=250.
REQ-031 Start held high with BCD=0x001 then 0x002 changed in the Done cycle -> back-to-back conversions; the second Done gives Bin=2 with no idle cycle between them.
REQ-032 Reset asserted during the 5th SHIFT cycle of 0x999 -> all outputs 0 asynchronously, no Done; after release, 0x321 -> Bin=321.
